// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, bubble
// instruction and reset PC defaults.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2,
    StHold = 2'd3
  } fetch_state_e;

  localparam logic [31:0] FetchNop     = 32'h0000_0013;
  localparam logic [31:0] FetchResetPc = 32'h0000_0000;

  // Sequential PC step; wraps naturally at 2^32.
  function automatic logic [31:0] fetch_next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction skid buffer; holds a response that arrived while the
// IF/ID register could not accept it. Clear has priority over load.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_valid
);

  logic [31:0] r_data;
  logic        r_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request handshake,
// IF/ID pipeline register and redirect/stall/flush handling.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FetchResetPc,
  parameter logic [31:0] NOP      = FetchNop
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_EN_IF,
  input  logic        reg_FD_stall,
  input  logic        reg_FD_flush,
  input  logic        Branch_ID,
  input  logic [31:0] PC_target_ID,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_ID,
  output logic [31:0] inst_ID,
  output logic        valid_ID,
  output logic        fetch_busy
);

  fetch_state_e r_state, w_state_next;
  logic [31:0]  r_pc, w_pc_next;
  logic [31:0]  r_addr;
  logic [31:0]  r_pc_id, w_pc_id_next;
  logic [31:0]  r_inst_id, w_inst_id_next;
  logic         r_valid_id, w_valid_id_next;

  logic         w_can_advance;
  logic         w_deliver;
  logic [31:0]  w_deliver_data;
  logic         w_skid_load, w_skid_clear, w_skid_valid;
  logic [31:0]  w_skid_data;

  // A response is only consumed into IF/ID when the whole front end may move.
  assign w_can_advance = PC_EN_IF & ~reg_FD_stall & ~reg_FD_flush;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (imem_rdata),
    .o_data  (w_skid_data),
    .o_valid (w_skid_valid)
  );

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_pc_id_next   = r_pc_id;
    w_inst_id_next = r_inst_id;
    w_valid_id_next = r_valid_id;
    w_deliver      = 1'b0;
    w_deliver_data = imem_rdata;
    w_skid_load    = 1'b0;
    w_skid_clear   = 1'b0;

    case (r_state)
      StReq, StWait: begin
        if (Branch_ID) begin
          // Without an ack the old request is still live and must be drained.
          w_state_next = imem_ack ? StReq : StDrop;
        end else if (imem_ack) begin
          if (w_can_advance) begin
            w_deliver    = 1'b1;
            w_state_next = StReq;
          end else begin
            w_skid_load  = 1'b1;
            w_state_next = StHold;
          end
        end else begin
          w_state_next = StWait;
        end
      end
      StDrop: begin
        if (imem_ack) w_state_next = StReq;
      end
      StHold: begin
        if (Branch_ID) begin
          w_skid_clear = 1'b1;
          w_state_next = StReq;
        end else if (w_can_advance) begin
          w_skid_clear   = 1'b1;
          w_state_next   = StReq;
          w_deliver      = w_skid_valid;
          w_deliver_data = w_skid_data;
        end
      end
      default: w_state_next = StReq;
    endcase

    if (w_deliver) w_pc_next = fetch_next_pc(r_pc);
    if (Branch_ID) w_pc_next = PC_target_ID;

    // Branch/flush always bubble; an unstalled slot with nothing new bubbles too.
    if (Branch_ID || reg_FD_flush || (!reg_FD_stall && !w_deliver)) begin
      w_inst_id_next  = NOP;
      w_valid_id_next = 1'b0;
    end else if (w_deliver) begin
      w_pc_id_next    = r_pc;
      w_inst_id_next  = w_deliver_data;
      w_valid_id_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StReq;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_pc_id    <= '0;
      r_inst_id  <= NOP;
      r_valid_id <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_pc_id    <= w_pc_id_next;
      r_inst_id  <= w_inst_id_next;
      r_valid_id <= w_valid_id_next;
      // Latch the issued address so it stays stable through WAIT/DROP.
      if (r_state == StReq) r_addr <= r_pc;
    end
  end

  // Gated by rst_n so no request is visible while reset is held.
  assign imem_req   = rst_n & (r_state != StHold);
  assign imem_addr  = (r_state == StReq) ? r_pc : r_addr;
  assign fetch_busy = (r_state == StWait) | (r_state == StDrop);
  assign PC_ID      = r_pc_id;
  assign inst_ID    = r_inst_id;
  assign valid_ID   = r_valid_id;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a fixed-latency memory model
// whose data is addr ^ 32'hA5A5_0000.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        PC_EN_IF;
  logic        reg_FD_stall;
  logic        reg_FD_flush;
  logic        Branch_ID;
  logic [31:0] PC_target_ID;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC_ID;
  logic [31:0] inst_ID;
  logic        valid_ID;
  logic        fetch_busy;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int mem_cnt = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP      (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PC_EN_IF     (PC_EN_IF),
    .reg_FD_stall (reg_FD_stall),
    .reg_FD_flush (reg_FD_flush),
    .Branch_ID    (Branch_ID),
    .PC_target_ID (PC_target_ID),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .PC_ID        (PC_ID),
    .inst_ID      (inst_ID),
    .valid_ID     (valid_ID),
    .fetch_busy   (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory acks after `lat` cycles of continuous request (lat=0: same cycle).
  assign imem_ack   = imem_req && (mem_cnt >= lat);
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;
  always @(posedge clk) begin
    if (!imem_req || imem_ack) mem_cnt <= 0;
    else mem_cnt <= mem_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l);
    lat = l;
    rst_n = 1'b0; PC_EN_IF = 1'b1; reg_FD_stall = 1'b0; reg_FD_flush = 1'b0;
    Branch_ID = 1'b0; PC_target_ID = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    lat = 1;
    rst_n = 1'b0; PC_EN_IF = 1'b1; reg_FD_stall = 1'b0; reg_FD_flush = 1'b0;
    Branch_ID = 1'b0; PC_target_ID = 32'h0;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    checks++; if (valid_ID !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_ID); end
    checks++; if (inst_ID !== 32'h13) begin errors++; $display("FAIL rst_inst got %h want 00000013", inst_ID); end
    checks++; if (PC_ID !== 32'h0) begin errors++; $display("FAIL rst_pc_id got %h want 0", PC_ID); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", fetch_busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_basic();
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL basic_addr%0d got %h want %h", k, imem_addr, 32'(4 * k)); end
      tick();
      checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL basic_busy%0d got %b want 1", k, fetch_busy); end
      tick();
      checks++; if (PC_ID !== 32'(4 * k)) begin errors++; $display("FAIL basic_pc%0d got %h want %h", k, PC_ID, 32'(4 * k)); end
      checks++; if (inst_ID !== (32'hA5A5_0000 | 32'(4 * k))) begin errors++; $display("FAIL basic_inst%0d got %h want %h", k, inst_ID, 32'hA5A5_0000 | 32'(4 * k)); end
      checks++; if (valid_ID !== 1'b1) begin errors++; $display("FAIL basic_valid%0d got %b want 1", k, valid_ID); end
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    repeat (4) tick();
    checks++; if (PC_ID !== 32'h4) begin errors++; $display("FAIL stall_pre got %h want 4", PC_ID); end
    reg_FD_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (PC_ID !== 32'h4 || valid_ID !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got %h/%b want 00000004/1", k, PC_ID, valid_ID); end
    end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq got %b want 0", imem_req); end
    reg_FD_stall = 1'b0;
    tick();
    checks++; if (PC_ID !== 32'h8) begin errors++; $display("FAIL stall_pc got %h want 8", PC_ID); end
    checks++; if (inst_ID !== 32'hA5A5_0008) begin errors++; $display("FAIL stall_inst got %h want a5a50008", inst_ID); end
    checks++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin errors++; $display("FAIL stall_next got %h/%b want 0000000c/1", imem_addr, imem_req); end
  endtask

  task automatic test_branch_wait();
    do_reset(3);
    repeat (12) tick();
    checks++; if (PC_ID !== 32'h8 || imem_addr !== 32'hC) begin errors++; $display("FAIL bw_pre got %h/%h want 8/c", PC_ID, imem_addr); end
    tick();
    Branch_ID = 1'b1; PC_target_ID = 32'h100;
    tick();
    Branch_ID = 1'b0;
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL bw_busy got %b want 1", fetch_busy); end
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL bw_oldaddr got %h want c", imem_addr); end
    checks++; if (valid_ID !== 1'b0 || inst_ID !== 32'h13) begin errors++; $display("FAIL bw_bubble got %b/%h want 0/00000013", valid_ID, inst_ID); end
    checks++; if (PC_ID !== 32'h8) begin errors++; $display("FAIL bw_pcid got %h want 8", PC_ID); end
    tick();
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL bw_drop_addr got %h want c", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h100 || fetch_busy !== 1'b0) begin errors++; $display("FAIL bw_target got %h/%b want 100/0", imem_addr, fetch_busy); end
    checks++; if (valid_ID !== 1'b0) begin errors++; $display("FAIL bw_discard got %b want 0", valid_ID); end
    repeat (4) tick();
    checks++; if (PC_ID !== 32'h100 || inst_ID !== 32'hA5A5_0100 || valid_ID !== 1'b1) begin errors++; $display("FAIL bw_fetch got %h/%h/%b want 100/a5a50100/1", PC_ID, inst_ID, valid_ID); end
  endtask

  task automatic test_branch_ack();
    do_reset(1);
    tick();
    Branch_ID = 1'b1; PC_target_ID = 32'h200;
    tick();
    Branch_ID = 1'b0;
    checks++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin errors++; $display("FAIL ba_addr got %h/%b want 200/1", imem_addr, imem_req); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL ba_nodrop got %b want 0", fetch_busy); end
    checks++; if (valid_ID !== 1'b0) begin errors++; $display("FAIL ba_discard got %b want 0", valid_ID); end
    repeat (2) tick();
    checks++; if (PC_ID !== 32'h200 || inst_ID !== 32'hA5A5_0200 || valid_ID !== 1'b1) begin errors++; $display("FAIL ba_fetch got %h/%h/%b want 200/a5a50200/1", PC_ID, inst_ID, valid_ID); end
  endtask

  task automatic test_wrap();
    do_reset(0);
    Branch_ID = 1'b1; PC_target_ID = 32'hFFFF_FFFC;
    tick();
    Branch_ID = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h want fffffffc", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
    checks++; if (PC_ID !== 32'hFFFF_FFFC || inst_ID !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_id got %h/%h want fffffffc/5a5afffc", PC_ID, inst_ID); end
    tick();
    checks++; if (PC_ID !== 32'h0 || valid_ID !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL wrap_next got %h/%b/%h want 0/1/4", PC_ID, valid_ID, imem_addr); end
  endtask

  task automatic test_flush();
    do_reset(0);
    tick();
    reg_FD_flush = 1'b1;
    tick();
    reg_FD_flush = 1'b0;
    checks++; if (valid_ID !== 1'b0 || inst_ID !== 32'h13 || PC_ID !== 32'h0) begin errors++; $display("FAIL flush_bubble got %b/%h/%h want 0/00000013/0", valid_ID, inst_ID, PC_ID); end
    tick();
    checks++; if (PC_ID !== 32'h4 || inst_ID !== 32'hA5A5_0004 || imem_addr !== 32'h8) begin errors++; $display("FAIL flush_resume got %h/%h/%h want 4/a5a50004/8", PC_ID, inst_ID, imem_addr); end
  endtask

  task automatic test_pc_en();
    do_reset(0);
    PC_EN_IF = 1'b0;
    repeat (2) tick();
    checks++; if (imem_req !== 1'b0 || valid_ID !== 1'b0) begin errors++; $display("FAIL pcen_hold got %b/%b want 0/0", imem_req, valid_ID); end
    PC_EN_IF = 1'b1;
    tick();
    checks++; if (PC_ID !== 32'h0 || valid_ID !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL pcen_resume got %h/%b/%h want 0/1/4", PC_ID, valid_ID, imem_addr); end
  endtask

  task automatic test_reset_wait();
    do_reset(3);
    repeat (4) tick();
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rw_pre got %h want 4", imem_addr); end
    tick();
    checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL rw_wait got %b want 1", fetch_busy); end
    rst_n = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_req got %b want 0", imem_req); end
    checks++; if (inst_ID !== 32'h13 || valid_ID !== 1'b0) begin errors++; $display("FAIL rw_id got %h/%b want 00000013/0", inst_ID, valid_ID); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rw_restart got %b/%h want 1/0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_branch_wait();
    test_branch_ack();
    test_wrap();
    test_flush();
    test_pc_en();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
